// File: rtl/clock_pkg.sv
// Shared clock/alarm types: alarm FSM encoding, time field widths and calendar constants.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_e;

  localparam int unsigned SEC_PER_MIN   = 60;
  localparam int unsigned HOURS_PER_DAY = 24;

  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned HR_W    = 5;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DATA_W  = 6;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_match.sv
// Alarm time registers with range-checked loads, and a one-shot trigger on entry into hh:mm:00.
module alarm_match
  import clock_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [SEC_W-1:0]  seconds_in,
  input  logic [MIN_W-1:0]  minutes_in,
  input  logic [HR_W-1:0]   hours_in,
  input  logic              alarm_load,
  input  logic [ADDR_W-1:0] alarm_addrs,
  input  logic [DATA_W-1:0] alarm_data,
  output logic [MIN_W-1:0]  alarm_min_o,
  output logic [HR_W-1:0]   alarm_hr_o,
  output logic              trigger_c
);

  logic [MIN_W-1:0] alarm_min_q, alarm_min_d;
  logic [HR_W-1:0]  alarm_hr_q,  alarm_hr_d;
  logic             match_c;
  logic             match_q;

  // Out-of-range data and reserved addresses leave the registers untouched.
  always_comb begin
    alarm_min_d = alarm_min_q;
    alarm_hr_d  = alarm_hr_q;
    if (alarm_load) begin
      case (alarm_addrs)
        2'd0: if (alarm_data < DATA_W'(SEC_PER_MIN))   alarm_min_d = MIN_W'(alarm_data);
        2'd1: if (alarm_data < DATA_W'(HOURS_PER_DAY)) alarm_hr_d  = alarm_data[HR_W-1:0];
        default: ;
      endcase
    end
  end

  assign match_c = (hours_in == alarm_hr_q) && (minutes_in == alarm_min_q) &&
                   (seconds_in == SEC_W'(0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_min_q <= '0;
      alarm_hr_q  <= '0;
      match_q     <= 1'b0;
    end else begin
      alarm_min_q <= alarm_min_d;
      alarm_hr_q  <= alarm_hr_d;
      match_q     <= match_c;
    end
  end

  // match_q resets low, so a match already present at reset release still fires.
  assign trigger_c   = match_c & ~match_q;
  assign alarm_min_o = alarm_min_q;
  assign alarm_hr_o  = alarm_hr_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: IDLE/RINGING/SNOOZE FSM with ring timeout, snooze timer and bounded snooze count.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tc_time_base,
  input  logic [SEC_W-1:0]   seconds_in,
  input  logic [MIN_W-1:0]   minutes_in,
  input  logic [HR_W-1:0]    hours_in,
  input  logic               alarm_enable,
  input  logic               alarm_load,
  input  logic [ADDR_W-1:0]  alarm_addrs,
  input  logic [DATA_W-1:0]  alarm_data,
  input  logic               snooze,
  input  logic               stop,
  output logic               alarm_on,
  output logic [STATE_W-1:0] alarm_state,
  output logic [MIN_W-1:0]   alarm_min_out,
  output logic [HR_W-1:0]    alarm_hr_out
);

  localparam int unsigned SNZ_TICKS = SNOOZE_MINUTES * SEC_PER_MIN;
  localparam int unsigned CNT_MAX   = max_u(RING_SECONDS, SNZ_TICKS);
  localparam int unsigned CNT_W     = max_u(1, $clog2(CNT_MAX + 1));
  localparam int unsigned SNZ_W     = max_u(1, $clog2(MAX_SNOOZE + 1));

  alarm_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
  logic             alarm_on_q;
  logic             trigger_c;

  alarm_match u_match (
    .clk         (clk),
    .reset       (reset),
    .seconds_in  (seconds_in),
    .minutes_in  (minutes_in),
    .hours_in    (hours_in),
    .alarm_load  (alarm_load),
    .alarm_addrs (alarm_addrs),
    .alarm_data  (alarm_data),
    .alarm_min_o (alarm_min_out),
    .alarm_hr_o  (alarm_hr_out),
    .trigger_c   (trigger_c)
  );

  // Next state: enable dominates, then stop, then snooze, then the 1 Hz countdown.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snz_cnt_d = snz_cnt_q;
    if (!alarm_enable) begin
      state_d   = IDLE;
      snz_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger_c) begin
            state_d = RINGING;
            cnt_d   = CNT_W'(RING_SECONDS);
          end
        end
        RINGING: begin
          if (stop) begin
            state_d   = IDLE;
            snz_cnt_d = '0;
          end else if (snooze && (snz_cnt_q < SNZ_W'(MAX_SNOOZE))) begin
            state_d   = SNOOZE;
            cnt_d     = CNT_W'(SNZ_TICKS);
            snz_cnt_d = snz_cnt_q + SNZ_W'(1);
          end else if (tc_time_base) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d   = IDLE;
              snz_cnt_d = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d   = IDLE;
            snz_cnt_d = '0;
          end else if (tc_time_base) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = RINGING;
              cnt_d   = CNT_W'(RING_SECONDS);
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Buzzer enable is registered from the next state so it tracks state_q exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      snz_cnt_q  <= '0;
      alarm_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      alarm_on_q <= (state_d == RINGING);
    end
  end

  assign alarm_on    = alarm_on_q;
  assign alarm_state = state_q;

endmodule
